// File: rtl/deb_pkg.sv
// deb_pkg: shared mode constants and counter-width helper for the multi-channel debouncer
package deb_pkg;
    localparam logic MODE_STRETCH  = 1'b0;
    localparam logic MODE_DEBOUNCE = 1'b1;
    function automatic int cnt_width(input int hold);
        return $clog2(hold + 1);
    endfunction
endpackage

// File: rtl/deb_chan.sv
// deb_chan: one channel (synchroniser, hold/stability counter, out flop); ports clk rst in mode mode_chg -> out busy
module deb_chan import deb_pkg::*; #(
    parameter int HOLD_CYCLES = 80000000,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = cnt_width(HOLD_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic mode,
    input  logic mode_chg,
    output logic out,
    output logic busy
);
    localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   s;
    assign s = sync_q[SYNC_STAGES-1];
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in};
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (mode_chg) begin
            cnt_d = '0;
        end else if (mode == MODE_STRETCH) begin
            if (s) begin
                out_d = 1'b1;
                cnt_d = HOLD_V;
            end else if (cnt_q == ONE) begin
                out_d = 1'b0;
                cnt_d = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - ONE;
            end
        end else begin
            if (s == out_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST_V) begin
                out_d = s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end
    assign out  = out_q;
    assign busy = cnt_q != '0;
endmodule

// File: rtl/deb_multi.sv
// deb_multi: CHANNELS-wide stretch/debounce conditioner; ports clk rst in mode -> out busy (+ rise fall with DEB_EDGE_PULSE_EN)
module deb_multi import deb_pkg::*; #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 80000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic                mode,
    output logic [CHANNELS-1:0] out,
`ifdef DEB_EDGE_PULSE_EN
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
`endif
    output logic [CHANNELS-1:0] busy
);
    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    logic mode_q, mode_d, mode_chg;
    assign mode_d   = mode;
    assign mode_chg = mode != mode_q;
    always_ff @(posedge clk) begin
        mode_q <= rst ? MODE_STRETCH : mode_d;
    end
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        deb_chan #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .in      (in[i]),
            .mode    (mode),
            .mode_chg(mode_chg),
            .out     (out[i]),
            .busy    (busy[i])
        );
    end
`ifdef DEB_EDGE_PULSE_EN
    logic [CHANNELS-1:0] out_d_q;
    always_ff @(posedge clk) begin
        out_d_q <= rst ? '0 : out;
    end
    assign rise = out & ~out_d_q;
    assign fall = ~out & out_d_q;
`endif
endmodule
